riscv_if_id_prefetch: RTL and testbench

//  Parametrised IF stage plus IF/ID pipeline register with an in-order instruction prefetch FIFO.
//  - Fetches sequentially from a 1-cycle-latency instruction memory and buffers up to FIFO_DEPTH words.
//  - Feeds the ID stage with PC, instruction, a valid bit and decoded instruction fields.
//  - Absorbs ID stalls (IF_ID_write=0) and flushes on branch redirects (PCSrc).

---
 rtl/riscv_if_id_prefetch.sv | 141 ++++++++++++++
 tb/tb_riscv_if_id_prefetch.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/riscv_if_id_prefetch.sv
// IF stage + IF/ID register with an in-order prefetch FIFO fed by a 1-cycle instruction memory.
// Optional performance counters (PERF_INSTR/PERF_STALL) are built when IFID_PERF_EN is defined.
module riscv_if_id_prefetch #(
  parameter int              XLEN       = 32,
  parameter int              FIFO_DEPTH = 4,
  parameter logic [XLEN-1:0] RESET_PC   = '0
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        PCSrc,
  input  logic                        PC_write,
  input  logic [XLEN-1:0]             PC_Branch,
  input  logic                        IF_ID_write,
  output logic                        IMEM_REQ,
  output logic [XLEN-1:0]             IMEM_ADDR,
  input  logic [31:0]                 IMEM_RDATA,
  output logic [XLEN-1:0]             PC_ID,
  output logic [31:0]                 INSTRUCTION_ID,
  output logic                        VALID_ID,
  output logic [6:0]                  OPCODE_ID,
  output logic [4:0]                  RD_ID,
  output logic [2:0]                  FUNCT3_ID,
  output logic [4:0]                  RS1_ID,
  output logic [4:0]                  RS2_ID,
  output logic [6:0]                  FUNCT7_ID,
  output logic [$clog2(FIFO_DEPTH):0] FIFO_COUNT
`ifdef IFID_PERF_EN
  ,
  output logic [31:0]                 PERF_INSTR,
  output logic [31:0]                 PERF_STALL
`endif
);

  localparam int          AW  = $clog2(FIFO_DEPTH);
  localparam int          CW  = AW + 1;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic [XLEN-1:0] pc_if;
  logic [XLEN-1:0] req_pc;
  logic            inflight;
  logic [AW-1:0]   rd_ptr;
  logic [AW-1:0]   wr_ptr;
  logic [CW-1:0]   count;
  logic [XLEN-1:0] pc_mem  [FIFO_DEPTH];
  logic [31:0]     ins_mem [FIFO_DEPTH];

  logic            fifo_empty;
  logic [CW:0]     occupancy;
  logic            issue;
  logic            arrive;
  logic            id_load;
  logic            pop;
  logic            bypass;
  logic            push;

  // Space check counts the in-flight word but not a same-cycle pop, so a response can always be pushed.
  assign fifo_empty = (count == '0);
  assign occupancy  = {1'b0, count} + (CW+1)'(inflight);
  assign issue      = PC_write & ~PCSrc & ~reset & (occupancy < (CW+1)'(FIFO_DEPTH));
  assign arrive     = inflight & ~PCSrc & ~reset;
  assign id_load    = IF_ID_write & ~PCSrc;
  assign pop        = id_load & ~fifo_empty;
  assign bypass     = id_load & fifo_empty & arrive;
  assign push       = arrive & ~bypass;

  assign IMEM_REQ   = issue;
  assign IMEM_ADDR  = pc_if;
  assign FIFO_COUNT = count;

  assign OPCODE_ID  = INSTRUCTION_ID[6:0];
  assign RD_ID      = INSTRUCTION_ID[11:7];
  assign FUNCT3_ID  = INSTRUCTION_ID[14:12];
  assign RS1_ID     = INSTRUCTION_ID[19:15];
  assign RS2_ID     = INSTRUCTION_ID[24:20];
  assign FUNCT7_ID  = INSTRUCTION_ID[31:25];

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_if          <= RESET_PC;
      req_pc         <= RESET_PC;
      inflight       <= 1'b0;
      rd_ptr         <= '0;
      wr_ptr         <= '0;
      count          <= '0;
      PC_ID          <= '0;
      INSTRUCTION_ID <= NOP;
      VALID_ID       <= 1'b0;
    end else if (PCSrc) begin
      // Redirect flushes buffered and in-flight fetches; PC_ID is left as is.
      pc_if          <= PC_Branch;
      inflight       <= 1'b0;
      rd_ptr         <= '0;
      wr_ptr         <= '0;
      count          <= '0;
      INSTRUCTION_ID <= NOP;
      VALID_ID       <= 1'b0;
    end else begin
      if (issue) pc_if <= pc_if + XLEN'(4);
      inflight <= issue;
      req_pc   <= pc_if;

      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;

      if (pop) begin
        PC_ID          <= pc_mem[rd_ptr];
        INSTRUCTION_ID <= ins_mem[rd_ptr];
        VALID_ID       <= 1'b1;
      end else if (bypass) begin
        PC_ID          <= req_pc;
        INSTRUCTION_ID <= IMEM_RDATA;
        VALID_ID       <= 1'b1;
      end else if (id_load) begin
        INSTRUCTION_ID <= NOP;
        VALID_ID       <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr]  <= req_pc;
      ins_mem[wr_ptr] <= IMEM_RDATA;
    end
  end

`ifdef IFID_PERF_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      PERF_INSTR <= '0;
      PERF_STALL <= '0;
    end else begin
      if (pop || bypass)           PERF_INSTR <= PERF_INSTR + 32'd1;
      if (!IF_ID_write && VALID_ID) PERF_STALL <= PERF_STALL + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_riscv_if_id_prefetch.sv
// Directed vector bench for riscv_if_id_prefetch with a tagged-word instruction memory model.
module tb_riscv_if_id_prefetch;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        PCSrc = 1'b0;
  logic        PC_write = 1'b1;
  logic [31:0] PC_Branch = '0;
  logic        IF_ID_write = 1'b1;
  logic        IMEM_REQ;
  logic [31:0] IMEM_ADDR;
  logic [31:0] IMEM_RDATA = 32'hDEAD_BEEF;
  logic [31:0] PC_ID;
  logic [31:0] INSTRUCTION_ID;
  logic        VALID_ID;
  logic [6:0]  OPCODE_ID;
  logic [4:0]  RD_ID;
  logic [2:0]  FUNCT3_ID;
  logic [4:0]  RS1_ID;
  logic [4:0]  RS2_ID;
  logic [6:0]  FUNCT7_ID;
  logic [2:0]  FIFO_COUNT;
`ifdef IFID_PERF_EN
  logic [31:0] PERF_INSTR;
  logic [31:0] PERF_STALL;
`endif

  riscv_if_id_prefetch dut (
    .clk(clk), .reset(reset), .PCSrc(PCSrc), .PC_write(PC_write), .PC_Branch(PC_Branch),
    .IF_ID_write(IF_ID_write), .IMEM_REQ(IMEM_REQ), .IMEM_ADDR(IMEM_ADDR), .IMEM_RDATA(IMEM_RDATA),
    .PC_ID(PC_ID), .INSTRUCTION_ID(INSTRUCTION_ID), .VALID_ID(VALID_ID),
    .OPCODE_ID(OPCODE_ID), .RD_ID(RD_ID), .FUNCT3_ID(FUNCT3_ID), .RS1_ID(RS1_ID),
    .RS2_ID(RS2_ID), .FUNCT7_ID(FUNCT7_ID), .FIFO_COUNT(FIFO_COUNT)
`ifdef IFID_PERF_EN
    , .PERF_INSTR(PERF_INSTR), .PERF_STALL(PERF_STALL)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] tag(input logic [31:0] a);
    return {8'hA5, a[23:0]};
  endfunction

  // Memory returns an address-tagged word the cycle after a request, garbage otherwise.
  always @(posedge clk) IMEM_RDATA <= IMEM_REQ ? tag(IMEM_ADDR) : 32'hDEAD_BEEF;

  typedef struct {
    logic        rst, pcsrc, pcw, ifw;
    logic [31:0] br;
    logic        req, vld, chkpc;
    logic [31:0] pc;
    logic [2:0]  cnt;
    logic [31:0] addr;
  } vec_t;

  vec_t vq[$];
  int   n_cmp = 0;
  int   n_err = 0;

  function automatic vec_t mk(input logic rst, pcsrc, pcw, ifw, input logic [31:0] br,
                              input logic req, vld, chkpc, input logic [31:0] pc,
                              input logic [2:0] cnt, input logic [31:0] addr);
    vec_t v;
    v.rst = rst; v.pcsrc = pcsrc; v.pcw = pcw; v.ifw = ifw; v.br = br;
    v.req = req; v.vld = vld; v.chkpc = chkpc; v.pc = pc; v.cnt = cnt; v.addr = addr;
    return v;
  endfunction

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s [%0d]: got %h expected %h", name, idx, act, exp);
    end
  endtask

  task automatic apply(input vec_t v, input int idx);
    logic [31:0] exp_ins;
    reset = v.rst; PCSrc = v.pcsrc; PC_write = v.pcw; IF_ID_write = v.ifw; PC_Branch = v.br;
    #2;
    chk("imem_req", idx, 32'(IMEM_REQ), 32'(v.req));
    @(posedge clk);
    #1;
    exp_ins = v.vld ? tag(v.pc) : 32'h0000_0013;
    chk("valid_id", idx, 32'(VALID_ID), 32'(v.vld));
    if (v.chkpc) chk("pc_id", idx, PC_ID, v.pc);
    chk("instr_id", idx, INSTRUCTION_ID, exp_ins);
    chk("fields", idx, {FUNCT7_ID, RS2_ID, RS1_ID, FUNCT3_ID, RD_ID, OPCODE_ID}, exp_ins);
    chk("fifo_count", idx, 32'(FIFO_COUNT), 32'(v.cnt));
    chk("imem_addr", idx, IMEM_ADDR, v.addr);
  endtask

  initial begin
    // rst pcsrc pcw ifw br | req vld chkpc pc cnt addr
    // Reset
    vq.push_back(mk(1,0,1,1,0,      0,0,1,0,     0,0));
    vq.push_back(mk(1,0,1,1,0,      0,0,1,0,     0,0));
    // Sequential fetch, one instruction per cycle from the second cycle
    vq.push_back(mk(0,0,1,1,0,      1,0,1,0,     0,4));
    vq.push_back(mk(0,0,1,1,0,      1,1,1,0,     0,8));
    vq.push_back(mk(0,0,1,1,0,      1,1,1,4,     0,12));
    vq.push_back(mk(0,0,1,1,0,      1,1,1,8,     0,16));
    // Stall 8 cycles: FIFO fills to 4 and fetch stops
    vq.push_back(mk(0,0,1,0,0,      1,1,1,8,     1,20));
    vq.push_back(mk(0,0,1,0,0,      1,1,1,8,     2,24));
    vq.push_back(mk(0,0,1,0,0,      1,1,1,8,     3,28));
    vq.push_back(mk(0,0,1,0,0,      0,1,1,8,     4,28));
    for (int k = 0; k < 4; k++) vq.push_back(mk(0,0,1,0,0, 0,1,1,8, 4,28));
    // Release: buffered PCs drain in order
    vq.push_back(mk(0,0,1,1,0,      0,1,1,12,    3,28));
    vq.push_back(mk(0,0,1,1,0,      1,1,1,16,    2,32));
    vq.push_back(mk(0,0,1,1,0,      1,1,1,20,    2,36));
    vq.push_back(mk(0,0,1,1,0,      1,1,1,24,    2,40));
    vq.push_back(mk(0,0,1,1,0,      1,1,1,28,    2,44));
    // Build count 3 + in-flight, then redirect to 0x100
    vq.push_back(mk(0,0,1,0,0,      1,1,1,28,    3,48));
    vq.push_back(mk(0,1,1,1,32'h100,0,0,0,0,     0,32'h100));
    vq.push_back(mk(0,0,1,1,0,      1,0,0,0,     0,32'h104));
    vq.push_back(mk(0,0,1,1,0,      1,1,1,32'h100,0,32'h108));
    vq.push_back(mk(0,0,1,1,0,      1,1,1,32'h104,0,32'h10C));
    // Redirect during ID stall
    vq.push_back(mk(0,1,1,0,32'h200,0,0,0,0,     0,32'h200));
    vq.push_back(mk(0,0,1,1,0,      1,0,0,0,     0,32'h204));
    vq.push_back(mk(0,0,1,1,0,      1,1,1,32'h200,0,32'h208));
    // PC_write low for 3 cycles: bubbles, PC_ID held, no skipped address
    vq.push_back(mk(0,0,0,1,0,      0,1,1,32'h204,0,32'h208));
    vq.push_back(mk(0,0,0,1,0,      0,0,1,32'h204,0,32'h208));
    vq.push_back(mk(0,0,0,1,0,      0,0,1,32'h204,0,32'h208));
    vq.push_back(mk(0,0,1,1,0,      1,0,1,32'h204,0,32'h20C));
    vq.push_back(mk(0,0,1,1,0,      1,1,1,32'h208,0,32'h210));
    vq.push_back(mk(0,0,1,1,0,      1,1,1,32'h20C,0,32'h214));
    // Reset mid-stream with two buffered entries
    vq.push_back(mk(0,0,1,0,0,      1,1,1,32'h20C,1,32'h218));
    vq.push_back(mk(0,0,1,0,0,      1,1,1,32'h20C,2,32'h21C));
    vq.push_back(mk(1,0,1,1,0,      0,0,1,0,     0,0));
    vq.push_back(mk(0,0,1,1,0,      1,0,1,0,     0,4));
    vq.push_back(mk(0,0,1,1,0,      1,1,1,0,     0,8));
    vq.push_back(mk(0,0,1,1,0,      1,1,1,4,     0,12));

    foreach (vq[i]) apply(vq[i], i);

    // Back-to-back redirects: only the last target is fetched
    apply(mk(0,1,1,1,32'h40,0,0,0,0,      0,32'h40), 100);
    apply(mk(0,1,1,1,32'h80,0,0,0,0,      0,32'h80), 101);
    apply(mk(0,0,1,1,0,     1,0,0,0,      0,32'h84), 102);
    apply(mk(0,0,1,1,0,     1,1,1,32'h80, 0,32'h88), 103);

`ifdef IFID_PERF_EN
    apply(mk(1,0,1,1,0,1'b0,0,1,0,0,0), 200);
    chk("perf_instr_rst", 200, PERF_INSTR, 32'd0);
    chk("perf_stall_rst", 200, PERF_STALL, 32'd0);
    apply(mk(0,0,1,1,0,1,0,1,0,0,4), 201);
    apply(mk(0,0,1,1,0,1,1,1,0,0,8), 202);
    chk("perf_instr", 202, PERF_INSTR, 32'd1);
    apply(mk(0,0,1,0,0,1,1,1,0,1,12), 203);
    chk("perf_stall", 203, PERF_STALL, 32'd1);
    chk("perf_instr_hold", 203, PERF_INSTR, 32'd1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
